// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: one requester's operation handshake and held response to the shared ALU sequencer.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    logic valid;
    logic ready;
    logic altOp;
    logic [3:0] func;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic respValid;
    logic respReady;
    logic [WIDTH-1:0] result;
    logic cond;
    modport master (
        output valid, altOp, func, data1, data2, respReady,
        input ready, respValid, result, cond
    );
    modport slave (
        input valid, altOp, func, data1, data2, respReady,
        output ready, respValid, result, cond
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one external ALU between execute (r0) and branch/compare (r1).
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int EXEC_CYCLES = 1
) (
    input  logic clk,
    input  logic reset_n,
    alu_share_arbiter_if.slave r0,
    alu_share_arbiter_if.slave r1,
    output logic alu_altOp,
    output logic [3:0] alu_func,
    output logic [WIDTH-1:0] alu_data1,
    output logic [WIDTH-1:0] alu_data2,
    input  logic [WIDTH-1:0] alu_dataOut,
    input  logic alu_beqOut
);
    typedef enum logic [1:0] {IDLE, SETTLE, RESP} stateType;
    stateType state, nextState;
    logic lastGrant, owner, accept, ownerDone;
    logic [3:0] count;
    logic [WIDTH-1:0] result;
    logic cond;

    // A tie goes to whichever requester was not served last.
    always_comb begin
        r0.ready = reset_n && state == IDLE && r0.valid && (!r1.valid || lastGrant);
        r1.ready = reset_n && state == IDLE && r1.valid && (!r0.valid || !lastGrant);
        accept = r0.ready || r1.ready;
        ownerDone = owner ? r1.respReady : r0.respReady;
        nextState = state == IDLE && accept ? SETTLE
                  : state == SETTLE && count == '0 ? RESP
                  : state == RESP && ownerDone ? IDLE : state;
        r0.respValid = state == RESP && !owner;
        r1.respValid = state == RESP && owner;
        r0.result = result;
        r1.result = result;
        r0.cond = cond;
        r1.cond = cond;
    end

    // The ALU only ever sees registered operands, never the live request buses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            lastGrant <= 1'b1;
            owner <= 1'b0;
            count <= '0;
            alu_altOp <= 1'b0;
            alu_func <= '0;
            alu_data1 <= '0;
            alu_data2 <= '0;
            result <= '0;
            cond <= 1'b0;
        end else begin
            state <= nextState;
            if (accept) begin
                owner <= r1.ready;
                lastGrant <= r1.ready;
                alu_altOp <= r1.ready ? r1.altOp : r0.altOp;
                alu_func <= r1.ready ? r1.func : r0.func;
                alu_data1 <= r1.ready ? r1.data1 : r0.data1;
                alu_data2 <= r1.ready ? r1.data2 : r0.data2;
                count <= 4'(EXEC_CYCLES - 1);
            end
            if (state == SETTLE) begin
                if (count != '0) count <= count - 4'd1;
                else begin
                    result <= alu_dataOut;
                    cond <= alu_beqOut;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: two arbiters (1- and 4-cycle settle) against a transaction-level model and ALU stub.
module tb_alu_share_arbiter;
    localparam int EXEC_TAB [2] = '{1, 4};
    logic clk = 1'b0;
    logic reset_n;
    logic v [2], alt [2], rr [2];
    logic [3:0] fn [2];
    logic [31:0] a1 [2], a2 [2];
    logic oReady [2][2], oRespV [2][2], oCond [2][2], oAlt [2];
    logic [31:0] oRes [2][2], oD1 [2], oD2 [2];
    logic [3:0] oFn [2];
    int checks = 0, errors = 0, cyc = 0, n;
    int grants [$];
    bit checkEn = 0;
    bit mBusy [2], mLast [2], mAlt [2], mCond [2];
    int mOwner [2], mRespAt [2];
    logic [3:0] mFn [2];
    logic [31:0] mD1 [2], mD2 [2], mRes [2];

    always #5 clk = ~clk;

    // Stand-in for the external ALU: {cond, result}.
    function automatic logic [32:0] aluRef(logic altOp, logic [3:0] func, logic [31:0] x, logic [31:0] y);
        logic c;
        if (!altOp) begin
            case (func)
                4'h0: return {1'b0, x + y};
                4'h1: return {1'b0, x - y};
                4'h2: return {1'b0, x & y};
                4'h3: return {1'b0, x | y};
                4'h6: return {1'b0, x ^ y};
                default: return '0;
            endcase
        end
        c = func == 4'h1 ? x == y : func == 4'h2 ? $signed(x) < $signed(y) : func == 4'h3 ? x < y : 1'b0;
        return {c, 31'b0, c};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        alu_share_arbiter_if #(.WIDTH(32)) q0 ();
        alu_share_arbiter_if #(.WIDTH(32)) q1 ();
        logic aluAltOp, aluBeqOut;
        logic [3:0] aluFunc;
        logic [31:0] aluData1, aluData2, aluDataOut;
        alu_share_arbiter #(.WIDTH(32), .EXEC_CYCLES(EXEC_TAB[g])) dut (
            .clk(clk), .reset_n(reset_n), .r0(q0), .r1(q1),
            .alu_altOp(aluAltOp), .alu_func(aluFunc), .alu_data1(aluData1), .alu_data2(aluData2),
            .alu_dataOut(aluDataOut), .alu_beqOut(aluBeqOut));
        assign {aluBeqOut, aluDataOut} = aluRef(aluAltOp, aluFunc, aluData1, aluData2);
        assign q0.valid = v[0];
        assign q0.altOp = alt[0];
        assign q0.func = fn[0];
        assign q0.data1 = a1[0];
        assign q0.data2 = a2[0];
        assign q0.respReady = rr[0];
        assign q1.valid = v[1];
        assign q1.altOp = alt[1];
        assign q1.func = fn[1];
        assign q1.data1 = a1[1];
        assign q1.data2 = a2[1];
        assign q1.respReady = rr[1];
        assign oReady[g][0] = q0.ready;
        assign oReady[g][1] = q1.ready;
        assign oRespV[g][0] = q0.respValid;
        assign oRespV[g][1] = q1.respValid;
        assign oRes[g][0] = q0.result;
        assign oRes[g][1] = q1.result;
        assign oCond[g][0] = q0.cond;
        assign oCond[g][1] = q1.cond;
        assign oAlt[g] = aluAltOp;
        assign oFn[g] = aluFunc;
        assign oD1[g] = aluData1;
        assign oD2[g] = aluData2;
    end

    task automatic checkVal(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Which requester the model would serve this cycle, -1 for none.
    function automatic int pickOf(int d);
        if (!reset_n || mBusy[d]) return -1;
        if (v[0] && v[1]) return mLast[d] ? 0 : 1;
        return v[0] ? 0 : v[1] ? 1 : -1;
    endfunction

    task automatic compare();
        for (int d = 0; d < 2; d++) begin
            int p;
            bit inResp;
            p = pickOf(d);
            inResp = mBusy[d] && cyc >= mRespAt[d];
            for (int k = 0; k < 2; k++) begin
                checkVal($sformatf("d%0d r%0d ready", d, k), oReady[d][k], p == k);
                checkVal($sformatf("d%0d r%0d respValid", d, k), oRespV[d][k], inResp && mOwner[d] == k);
                checkVal($sformatf("d%0d r%0d result", d, k), oRes[d][k], mRes[d]);
                checkVal($sformatf("d%0d r%0d cond", d, k), oCond[d][k], mCond[d]);
            end
            checkVal($sformatf("d%0d alu_altOp", d), oAlt[d], mAlt[d]);
            checkVal($sformatf("d%0d alu_func", d), oFn[d], mFn[d]);
            checkVal($sformatf("d%0d alu_data1", d), oD1[d], mD1[d]);
            checkVal($sformatf("d%0d alu_data2", d), oD2[d], mD2[d]);
        end
    endtask

    // An operation accepted in cycle c is answered from cycle c+1+EXEC until its owner takes it.
    task automatic advance();
        for (int d = 0; d < 2; d++) begin
            int p;
            p = pickOf(d);
            if (!reset_n) begin
                mBusy[d] = 0; mLast[d] = 1; mAlt[d] = 0; mFn[d] = '0;
                mD1[d] = '0; mD2[d] = '0; mRes[d] = '0; mCond[d] = 0;
            end else if (mBusy[d] && cyc >= mRespAt[d]) begin
                if (rr[mOwner[d]]) mBusy[d] = 0;
            end else if (mBusy[d]) begin
                if (cyc + 1 == mRespAt[d]) {mCond[d], mRes[d]} = aluRef(mAlt[d], mFn[d], mD1[d], mD2[d]);
            end else if (p >= 0) begin
                mBusy[d] = 1; mOwner[d] = p; mLast[d] = p == 1;
                mAlt[d] = alt[p]; mFn[d] = fn[p]; mD1[d] = a1[p]; mD2[d] = a2[p];
                mRespAt[d] = cyc + 1 + EXEC_TAB[d];
            end
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        if (checkEn) compare();
        advance();
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(int k, logic valid, logic altOp, logic [3:0] func, logic [31:0] x, logic [31:0] y);
        v[k] = valid; alt[k] = altOp; fn[k] = func; a1[k] = x; a2[k] = y;
        #1;
    endtask

    task automatic drain();
        int c = 0;
        v[0] = 0; v[1] = 0; rr[0] = 1; rr[1] = 1;
        while ((mBusy[0] || mBusy[1]) && c < 40) begin step(); c++; end
        checkVal("drain idle", {oRespV[0][0], oRespV[0][1], oRespV[1][0], oRespV[1][1]}, 0);
    endtask

    task automatic doReset();
        v[0] = 0; v[1] = 0; reset_n = 0;
        step();
        reset_n = 1;
    endtask

    task automatic runOp(int d, int k, logic altOp, logic [3:0] func, logic [31:0] x, logic [31:0] y,
                         logic [31:0] expRes, logic expCond, int expLat, string tag);
        int c = 0;
        rr[k] = 1;
        setReq(k, 1, altOp, func, x, y);
        while (!oReady[d][k] && c < 20) begin step(); c++; end
        checkVal({tag, " accept"}, oReady[d][k], 1);
        step();
        v[k] = 0;
        c = 1;
        while (!oRespV[d][k] && c < 30) begin step(); c++; end
        checkVal({tag, " latency"}, c, expLat);
        checkVal({tag, " result"}, oRes[d][k], expRes);
        checkVal({tag, " cond"}, oCond[d][k], expCond);
        step();
        checkVal({tag, " release"}, oRespV[d][k], 0);
        drain();
    endtask

    initial begin
        reset_n = 0;
        v = '{0, 0}; alt = '{0, 0}; rr = '{1, 1};
        fn = '{4'h0, 4'h0}; a1 = '{32'h0, 32'h0}; a2 = '{32'h0, 32'h0};
        step();
        checkEn = 1;
        step();
        reset_n = 1;
        runOp(0, 0, 0, 4'h0, 32'd5, 32'd7, 32'd12, 0, 2, "add");
        // Both requesters held valid: service alternates starting with r0.
        doReset();
        setReq(0, 1, 0, 4'h0, 32'd3, 32'd4);
        setReq(1, 1, 1, 4'h1, 32'd9, 32'd9);
        n = 0;
        while (grants.size() < 4 && n < 60) begin
            if (oReady[0][0]) grants.push_back(0);
            else if (oReady[0][1]) grants.push_back(1);
            if (oRespV[0][1]) begin
                checkVal("rr r1 result", oRes[0][1], 1);
                checkVal("rr r1 cond", oCond[0][1], 1);
            end
            step();
            n++;
        end
        checkVal("rr grant count", grants.size(), 4);
        foreach (grants[i]) checkVal($sformatf("rr grant %0d", i), grants[i], i % 2);
        drain();
        runOp(0, 0, 1, 4'h2, 32'hFFFF_FFFD, 32'd2, 32'd1, 1, 2, "slt");
        runOp(0, 0, 1, 4'hB, 32'hFFFF_FFFD, 32'd2, 32'd0, 0, 2, "unsupported");
        // Response held back by r0 while r1 waits.
        rr[0] = 0;
        setReq(0, 1, 0, 4'h1, 32'd100, 32'd30);
        n = 0;
        while (!oReady[0][0] && n < 20) begin step(); n++; end
        step();
        v[0] = 0;
        n = 0;
        while (!oRespV[0][0] && n < 20) begin step(); n++; end
        setReq(1, 1, 1, 4'h1, 32'd9, 32'd9);
        for (int i = 0; i < 5; i++) begin
            checkVal("hold respValid", oRespV[0][0], 1);
            checkVal("hold result", oRes[0][0], 32'd70);
            checkVal("hold cond", oCond[0][0], 0);
            checkVal("hold r0 ready", oReady[0][0], 0);
            checkVal("hold r1 ready", oReady[0][1], 0);
            step();
        end
        rr[0] = 1;
        #1;
        step();
        checkVal("hold r1 granted", oReady[0][1], 1);
        drain();
        runOp(1, 1, 0, 4'h6, 32'hF0, 32'hFF, 32'h0F, 0, 5, "xor slow");
        // Reset while the slow instance is settling abandons the operation.
        setReq(0, 1, 0, 4'h0, 32'd40, 32'd2);
        n = 0;
        while (!oReady[1][0] && n < 20) begin step(); n++; end
        step();
        v[0] = 0;
        step();
        step();
        reset_n = 0;
        step();
        reset_n = 1;
        #1;
        checkVal("abort alu_data1", oD1[1], 0);
        checkVal("abort alu_data2", oD2[1], 0);
        checkVal("abort alu_func", oFn[1], 0);
        for (int i = 0; i < 6; i++) begin
            checkVal("abort no resp", {oRespV[1][0], oRespV[1][1]}, 0);
            step();
        end
        runOp(1, 0, 0, 4'h0, 32'd1, 32'd1, 32'd2, 0, 5, "after abort");
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 2; k++) begin
                v[k] = $urandom_range(0, 2) != 0;
                alt[k] = 1'($urandom_range(0, 1));
                fn[k] = $urandom_range(0, 5) == 0 ? 4'($urandom) : $urandom_range(0, 4) == 0 ? 4'h6 : 4'($urandom_range(0, 3));
                a1[k] = $urandom;
                a2[k] = $urandom_range(0, 3) == 0 ? a1[k] : $urandom;
                rr[k] = $urandom_range(0, 3) != 0;
            end
            reset_n = $urandom_range(0, 99) != 0;
            step();
        end
        reset_n = 1;
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
